screen_sequencer: RTL and testbench
===================================

# screen_sequencer

Parametrised top-level screen sequencer for the chess game. It walks TITLE → PLAYER → SETUP → CHESS, then WON_END or LOST_END, and returns to TITLE for a new game. Splash and end-screen hold times are programmable, game-result inputs are live, `enter` is edge-qualified, and games are counted. It sits between the debounced button/switch inputs and the video screen mux and board-setup logic.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, clock frequency; must be a multiple of 1000.
- `PLAYER_HOLD_MS`, 2000, PLAYER_SCREEN dwell time; must be ≥1 ms.
- `END_HOLD_MS`, 3000, minimum END screen dwell before `enter` is accepted; 0 means accept immediately.
- `GAME_CNT_W`, 8, width of `games_played`.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enter`  in  1  debounced button level; only its rising edge is used.
- `override`  in  1  level; skips directly to CHESS_SCREEN (debug).
- `won`  in  1  level; local player won; sampled only in CHESS_SCREEN.
- `lost`  in  1  level; local player lost; sampled only in CHESS_SCREEN.
- `state`  out  screen_state_t  current screen; reset value TITLE_SCREEN.
- `setup_complete`  out  1  one-cycle pulse on SETUP→CHESS via `enter`; reset value 0.
- `state_changed`  out  1  high for the first cycle of every new state; reset value 0.
- `game_over`  out  1  high while `state` is WON_END_SCREEN or LOST_END_SCREEN; reset value 0.
- `games_played`  out  GAME_CNT_W  count of completed games, saturating; reset value 0.

## Operation
- Edge detection: `enter_q` is registered; `enter_rise = enter & ~enter_q`. `enter_q` resets to 0, so `enter` held through reset release counts as a rise on the first cycle.
- Cycle constants: `PLAYER_CYC = CLK_FREQ_HZ/1000*PLAYER_HOLD_MS` and `END_CYC = CLK_FREQ_HZ/1000*END_HOLD_MS`.
- Hold counter width: `$clog2(max(PLAYER_CYC,END_CYC)+1)`.
- Hold counter behaviour: cleared on every state change, otherwise increments. It saturates at its maximum in END states.
- TITLE: `override` → CHESS. Otherwise `enter_rise` → PLAYER. Otherwise stay.
- PLAYER: `override` → CHESS. Otherwise leave for SETUP when the counter equals `PLAYER_CYC-1`, so PLAYER lasts exactly `PLAYER_CYC` cycles. `enter` is ignored.
- SETUP:
  - `enter_rise` → CHESS and `setup_complete` pulses. This applies even when `override` is also high.
  - `override` alone → CHESS with no pulse.
- CHESS:
  - `won` → WON_END.
  - `lost` → LOST_END.
  - Both high → WON_END (won has priority).
  - `enter` and `override` are ignored.
- WON_END / LOST_END:
  - `enter_rise` is ignored while counter < `END_CYC`.
  - Once counter ≥ `END_CYC`, `enter_rise` → TITLE. With `END_HOLD_MS=0`, the first `enter_rise` is accepted.
  - `override` is ignored.
- `games_played` increments by 1 on every CHESS→END transition and saturates at all-ones.
- Illegal state encoding → TITLE on the next cycle; no other side effects.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Next-state latency: an input qualifying at edge N shows up in `state` after edge N.
- `setup_complete` and `state_changed` go high in the same cycle `state` first shows the new value. Each is high for exactly one cycle.
- `game_over` and `games_played` update in the same cycle `state` enters END.
- END→TITLE: `enter` must be released and pressed again before TITLE can advance, so a single held press never skips TITLE.
- Reset mid-operation: all outputs, the counter and `enter_q` return to reset values immediately (asynchronously).

## Structure
- `screen_state_t` stays in the shared `common_enums` package, unchanged: TITLE, PLAYER, SETUP, CHESS, WON_END, LOST_END.
- The cycle constants and counter width are localparams inside the module.
- An elaboration-time `$error` fires if `CLK_FREQ_HZ % 1000 != 0` or `PLAYER_HOLD_MS == 0`.
- One sub-module, `screen_hold_timer`:
  - Parameter: width.
  - Inputs: `clear` and `enable`.
  - Output: `count`, saturating.
  - The sequencer itself holds only the next-state logic and output registers.

## Test plan
All scenarios use `CLK_FREQ_HZ=1000` (1 cycle/ms), `PLAYER_HOLD_MS=4`, `END_HOLD_MS=3`, `GAME_CNT_W=2`.
- Full flow:
  - Stimulus: `enter` pulse in TITLE; wait; `enter` pulse in SETUP; `won=1`.
  - Required: PLAYER for exactly 4 cycles, then SETUP; `setup_complete` high for one cycle with `state`=CHESS; WON_END one cycle after `won`; `games_played`=1; `game_over`=1.
- Held enter:
  - Stimulus: `enter` held high from the TITLE press through PLAYER and SETUP.
  - Required: stays in SETUP; a release then press → CHESS.
- End hold:
  - Stimulus: in LOST_END, `enter` rises at counter 1.
  - Required: ignored. A rise at counter ≥3 → TITLE next cycle with `state_changed`=1.
- Priorities:
  - Stimulus: `won=lost=1` in CHESS.
  - Required: WON_END.
  - Stimulus: `override` and `enter` together in SETUP.
  - Required: CHESS with `setup_complete`=1.
  - Stimulus: `override` in PLAYER at cycle 2.
  - Required: CHESS; SETUP never entered.
- Saturation:
  - Stimulus: 5 complete games.
  - Required: `games_played` = 1, 2, 3, 3, 3.
- Reset mid-PLAYER:
  - Stimulus: assert `reset` asynchronously between edges.
  - Required: `state`=TITLE and all pulses 0 before the next edge. After release with `enter` held, the first edge → PLAYER.

Source files
------------

// File: rtl/common_enums.sv
// Shared enumerations for the chess game top level.
package common_enums;

  // Screens shown by the video mux, in game-flow order.
  typedef enum logic [2:0] {
    TITLE_SCREEN    = 3'd0,
    PLAYER_SCREEN   = 3'd1,
    SETUP_SCREEN    = 3'd2,
    CHESS_SCREEN    = 3'd3,
    WON_END_SCREEN  = 3'd4,
    LOST_END_SCREEN = 3'd5
  } screen_state_t;

  // True for either end-of-game screen.
  function automatic logic is_end_screen(input screen_state_t s);
    return (s == WON_END_SCREEN) || (s == LOST_END_SCREEN);
  endfunction

endpackage

// File: rtl/screen_hold_timer.sv
// Dwell counter for the screen sequencer: cleared on a screen change,
// otherwise counts enabled cycles and sticks at all-ones.
module screen_hold_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Saturating up-counter with synchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Top-level screen flow: TITLE -> PLAYER -> SETUP -> CHESS -> WON/LOST END
// -> TITLE. Splash and end-screen dwell times come from a hold timer; all
// outputs are registered.
//
// Handshake note: there is no valid/ready traffic here. `enter` is a
// debounced level of which only the rising edge acts; `override`, `won`
// and `lost` are levels sampled every cycle in the states that use them.
module screen_sequencer
  import common_enums::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int PLAYER_HOLD_MS = 2000,
  parameter int END_HOLD_MS    = 3000,
  parameter int GAME_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enter,
  input  logic                  override,
  input  logic                  won,
  input  logic                  lost,
  output screen_state_t         state,
  output logic                  setup_complete,
  output logic                  state_changed,
  output logic                  game_over,
  output logic [GAME_CNT_W-1:0] games_played
);

  localparam int PLAYER_CYC = CLK_FREQ_HZ / 1000 * PLAYER_HOLD_MS;
  localparam int END_CYC    = CLK_FREQ_HZ / 1000 * END_HOLD_MS;
  localparam int MAX_CYC    = (PLAYER_CYC > END_CYC) ? PLAYER_CYC : END_CYC;
  localparam int CNT_W      = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PLAYER_LAST = CNT_W'(PLAYER_CYC - 1);
  localparam logic [CNT_W-1:0] END_MIN     = CNT_W'(END_CYC);

  if ((CLK_FREQ_HZ % 1000 != 0) || (PLAYER_HOLD_MS == 0)) begin : g_param_check
    $error("screen_sequencer: CLK_FREQ_HZ must be a multiple of 1000 and PLAYER_HOLD_MS >= 1");
  end

  logic             enter_q;
  logic             enter_rise;
  logic [CNT_W-1:0] hold_count;
  logic             hold_enable;
  screen_state_t    next_state;
  logic             leaving;

  assign enter_rise  = enter & ~enter_q;
  assign leaving     = (next_state != state);
  assign hold_enable = (state == PLAYER_SCREEN) || is_end_screen(state);

  screen_hold_timer #(
    .WIDTH(CNT_W)
  ) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .clear (leaving),
    .enable(hold_enable),
    .count (hold_count)
  );

  // Remember last cycle's enter level for rising-edge qualification.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enter_q <= 1'b0;
    end else begin
      enter_q <= enter;
    end
  end

  // Screen transition rules; unknown encodings fall back to TITLE.
  always_comb begin
    next_state = state;
    case (state)
      TITLE_SCREEN: begin
        if (override)        next_state = CHESS_SCREEN;
        else if (enter_rise) next_state = PLAYER_SCREEN;
      end
      PLAYER_SCREEN: begin
        if (override)                        next_state = CHESS_SCREEN;
        else if (hold_count == PLAYER_LAST)  next_state = SETUP_SCREEN;
      end
      SETUP_SCREEN: begin
        if (enter_rise || override) next_state = CHESS_SCREEN;
      end
      CHESS_SCREEN: begin
        if (won)       next_state = WON_END_SCREEN;
        else if (lost) next_state = LOST_END_SCREEN;
      end
      WON_END_SCREEN, LOST_END_SCREEN: begin
        if (enter_rise && (hold_count >= END_MIN)) next_state = TITLE_SCREEN;
      end
      default: next_state = TITLE_SCREEN;
    endcase
  end

  // State register plus every output, all updated on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= TITLE_SCREEN;
      setup_complete <= 1'b0;
      state_changed  <= 1'b0;
      game_over      <= 1'b0;
      games_played   <= '0;
    end else begin
      state          <= next_state;
      setup_complete <= (state == SETUP_SCREEN) && enter_rise;
      state_changed  <= leaving;
      game_over      <= is_end_screen(next_state);
      if ((state == CHESS_SCREEN) && is_end_screen(next_state) &&
          (games_played != {GAME_CNT_W{1'b1}})) begin
        games_played <= games_played + GAME_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: directed scenario tasks with inline checks
// followed by a randomized run against a behavioural reference model.
module tb_screen_sequencer;
  import common_enums::*;

  localparam int PLAYER_MS = 4;
  localparam int END_MS    = 3;
  localparam int GMAX      = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enter = 1'b0;
  logic          override = 1'b0;
  logic          won = 1'b0;
  logic          lost = 1'b0;
  screen_state_t state;
  logic          setup_complete;
  logic          state_changed;
  logic          game_over;
  logic [1:0]    games_played;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: screen, cycles already spent on it, previous enter level.
  screen_state_t m_state;
  int            m_dwell;
  logic          m_prev_enter;
  int            m_games;
  logic          m_setup;
  logic          m_changed;
  logic [7:0]    exp_q[$];

  screen_sequencer #(
    .CLK_FREQ_HZ   (1000),
    .PLAYER_HOLD_MS(PLAYER_MS),
    .END_HOLD_MS   (END_MS),
    .GAME_CNT_W    (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enter         (enter),
    .override      (override),
    .won           (won),
    .lost          (lost),
    .state         (state),
    .setup_complete(setup_complete),
    .state_changed (state_changed),
    .game_over     (game_over),
    .games_played  (games_played)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic model_is_end(input screen_state_t s);
    return (s == WON_END_SCREEN) || (s == LOST_END_SCREEN);
  endfunction

  task automatic model_reset();
    m_state      = TITLE_SCREEN;
    m_dwell      = 0;
    m_prev_enter = 1'b0;
    m_games      = 0;
    m_setup      = 1'b0;
    m_changed    = 1'b0;
    exp_q.delete();
  endtask

  // Apply the game-flow rules for one clock edge.
  task automatic model_step(input logic e, input logic o, input logic w, input logic l);
    logic          rise;
    screen_state_t nxt;
    rise = e && !m_prev_enter;
    nxt  = m_state;
    if (m_state == TITLE_SCREEN) begin
      if (o) nxt = CHESS_SCREEN;
      else if (rise) nxt = PLAYER_SCREEN;
    end else if (m_state == PLAYER_SCREEN) begin
      if (o) nxt = CHESS_SCREEN;
      else if (m_dwell + 1 == PLAYER_MS) nxt = SETUP_SCREEN;
    end else if (m_state == SETUP_SCREEN) begin
      if (rise || o) nxt = CHESS_SCREEN;
    end else if (m_state == CHESS_SCREEN) begin
      if (w) nxt = WON_END_SCREEN;
      else if (l) nxt = LOST_END_SCREEN;
    end else begin
      if (rise && m_dwell >= END_MS) nxt = TITLE_SCREEN;
    end
    m_setup   = (m_state == SETUP_SCREEN) && rise;
    m_changed = (nxt != m_state);
    if (m_state == CHESS_SCREEN && model_is_end(nxt)) m_games = (m_games + 1 > GMAX) ? GMAX : m_games + 1;
    m_dwell      = m_changed ? 0 : m_dwell + 1;
    m_state      = nxt;
    m_prev_enter = e;
    exp_q.push_back({m_state, m_setup, m_changed, model_is_end(m_state), 2'(m_games)});
  endtask

  // Driver: set inputs, advance one edge, land 1 time unit after it.
  task automatic cycle(input logic e, input logic o, input logic w, input logic l);
    enter = e; override = o; won = w; lost = l;
    model_step(e, o, w, l);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enter = 1'b0; override = 1'b0; won = 1'b0; lost = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Leave an END screen: wait out the hold, then a fresh press.
  task automatic exit_end();
    repeat (END_MS) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (state !== TITLE_SCREEN) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, TITLE_SCREEN); end
    n_checks++; if (setup_complete !== 1'b0) begin n_fail++; $display("FAIL reset_setup: got %b want 0", setup_complete); end
    n_checks++; if (state_changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %b want 0", state_changed); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    n_checks++; if (games_played !== 2'd0) begin n_fail++; $display("FAIL reset_games: got %0d want 0", games_played); end
  endtask

  task automatic test_full_flow();
    int n_player;
    cycle(1, 0, 0, 0);
    n_checks++; if (state !== PLAYER_SCREEN || state_changed !== 1'b1) begin n_fail++; $display("FAIL flow_enter_player: state %0d chg %b want %0d 1", state, state_changed, PLAYER_SCREEN); end
    n_player = 1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0);
      if (state != PLAYER_SCREEN) break;
      n_player++;
    end
    n_checks++; if (n_player != PLAYER_MS || state !== SETUP_SCREEN) begin n_fail++; $display("FAIL flow_player_len: %0d cycles then state %0d want %0d then %0d", n_player, state, PLAYER_MS, SETUP_SCREEN); end
    cycle(1, 0, 0, 0);
    n_checks++; if (state !== CHESS_SCREEN || setup_complete !== 1'b1) begin n_fail++; $display("FAIL flow_setup_done: state %0d setup %b want %0d 1", state, setup_complete, CHESS_SCREEN); end
    cycle(0, 0, 0, 0);
    n_checks++; if (setup_complete !== 1'b0 || state_changed !== 1'b0) begin n_fail++; $display("FAIL flow_pulse_width: setup %b chg %b want 0 0", setup_complete, state_changed); end
    cycle(0, 0, 1, 0);
    n_checks++; if (state !== WON_END_SCREEN || games_played !== 2'd1 || game_over !== 1'b1) begin n_fail++; $display("FAIL flow_won: state %0d games %0d over %b want %0d 1 1", state, games_played, game_over, WON_END_SCREEN); end
    won = 1'b0;
    exit_end();
    n_checks++; if (state !== TITLE_SCREEN || game_over !== 1'b0) begin n_fail++; $display("FAIL flow_back_title: state %0d over %b want %0d 0", state, game_over, TITLE_SCREEN); end
  endtask

  task automatic test_held_enter();
    cycle(1, 0, 0, 0);
    repeat (8) cycle(1, 0, 0, 0);
    n_checks++; if (state !== SETUP_SCREEN) begin n_fail++; $display("FAIL held_stays_setup: state %0d want %0d", state, SETUP_SCREEN); end
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    n_checks++; if (state !== CHESS_SCREEN || setup_complete !== 1'b1) begin n_fail++; $display("FAIL held_repress: state %0d setup %b want %0d 1", state, setup_complete, CHESS_SCREEN); end
  endtask

  task automatic test_end_hold();
    cycle(0, 0, 0, 1);
    n_checks++; if (state !== LOST_END_SCREEN || game_over !== 1'b1) begin n_fail++; $display("FAIL hold_lost: state %0d over %b want %0d 1", state, game_over, LOST_END_SCREEN); end
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    n_checks++; if (state !== LOST_END_SCREEN) begin n_fail++; $display("FAIL hold_early_enter: state %0d want %0d", state, LOST_END_SCREEN); end
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    n_checks++; if (state !== TITLE_SCREEN || state_changed !== 1'b1) begin n_fail++; $display("FAIL hold_late_enter: state %0d chg %b want %0d 1", state, state_changed, TITLE_SCREEN); end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_priorities();
    logic saw_setup;
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 1);
    n_checks++; if (state !== WON_END_SCREEN) begin n_fail++; $display("FAIL prio_won_lost: state %0d want %0d", state, WON_END_SCREEN); end
    exit_end();
    cycle(1, 0, 0, 0);
    repeat (PLAYER_MS) cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    n_checks++; if (state !== CHESS_SCREEN || setup_complete !== 1'b1) begin n_fail++; $display("FAIL prio_setup_override_enter: state %0d setup %b want %0d 1", state, setup_complete, CHESS_SCREEN); end
    cycle(0, 0, 1, 0);
    exit_end();
    saw_setup = 1'b0;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    if (state == SETUP_SCREEN) saw_setup = 1'b1;
    cycle(0, 1, 0, 0);
    n_checks++; if (state !== CHESS_SCREEN || saw_setup || setup_complete !== 1'b0) begin n_fail++; $display("FAIL prio_player_override: state %0d saw_setup %b setup %b want %0d 0 0", state, saw_setup, setup_complete, CHESS_SCREEN); end
    cycle(0, 0, 0, 1);
    exit_end();
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0);
      want = (g + 1 > GMAX) ? GMAX : g + 1;
      n_checks++; if (games_played !== 2'(want)) begin n_fail++; $display("FAIL sat_game%0d: got %0d want %0d", g + 1, games_played, want); end
      exit_end();
    end
  endtask

  task automatic test_reset_mid_player();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    #2;
    reset = 1'b1;
    enter = 1'b1;
    #1;
    n_checks++; if (state !== TITLE_SCREEN || setup_complete !== 1'b0 || state_changed !== 1'b0 || game_over !== 1'b0 || games_played !== 2'd0) begin
      n_fail++; $display("FAIL async_reset: state %0d setup %b chg %b over %b games %0d want %0d 0 0 0 0", state, setup_complete, state_changed, game_over, games_played, TITLE_SCREEN);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1, 0, 0, 0);
    n_checks++; if (state !== PLAYER_SCREEN) begin n_fail++; $display("FAIL reset_held_enter: state %0d want %0d", state, PLAYER_SCREEN); end
  endtask

  task automatic test_random();
    logic [7:0] observed;
    logic [7:0] expected;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      observed = {state, setup_complete, state_changed, game_over, games_played};
      expected = exp_q.pop_front();
      n_checks++;
      if (observed !== expected) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got st=%0d sc=%b chg=%b go=%b gp=%0d want st=%0d sc=%b chg=%b go=%b gp=%0d",
                 i, observed[7:5], observed[4], observed[3], observed[2], observed[1:0],
                 expected[7:5], expected[4], expected[3], expected[2], expected[1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_flow();
    test_held_enter();
    test_end_hold();
    test_priorities();
    test_saturation();
    test_reset_mid_player();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
